// File: rtl/load_store_unit.sv
// load_store_unit: in-order load/store queue that serialises dual-lane dispatch onto one data-memory port
// Ports: clock_i / reset_i (async, active-low); lane A/B dispatch (enable, writeback flag/register,
//   opcode, address operand, store data); stall_o back-pressure to dispatch; memReq_o/memWe_o/
//   memAddr_o/memWdata_o request held until memAck_i, with load data on memRdata_i;
//   wbEnable_o/wbAddress_o/wbData_o load writeback; illegal_o bad-opcode pulse; overflow_o sticky drop flag.
module load_store_unit #(
  parameter int         QUEUE_DEPTH  = 4,
  parameter logic [6:0] LOAD_OPCODE  = 7'h20,
  parameter logic [6:0] STORE_OPCODE = 7'h21
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        lsEnableA_i,
  input  logic        lsEnableB_i,
  input  logic        isWbLSA_i,
  input  logic        isWbLSB_i,
  input  logic [4:0]  lsWbAddressA_i,
  input  logic [4:0]  lsWbAddressB_i,
  input  logic [6:0]  lsOpCodeA_i,
  input  logic [6:0]  lsOpCodeB_i,
  input  logic [15:0] lsPoperandA_i,
  input  logic [15:0] lsPoperandB_i,
  input  logic [15:0] lsSoperandA_i,
  input  logic [15:0] lsSoperandB_i,
  output logic        stall_o,
  output logic        memReq_o,
  output logic        memWe_o,
  output logic [15:0] memAddr_o,
  output logic [15:0] memWdata_o,
  input  logic        memAck_i,
  input  logic [15:0] memRdata_i,
  output logic        wbEnable_o,
  output logic [4:0]  wbAddress_o,
  output logic [15:0] wbData_o,
  output logic        illegal_o,
  output logic        overflow_o
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic        st;
    logic        wb;
    logic [4:0]  wa;
    logic [15:0] addr;
    logic [15:0] wd;
  } entry_t;

  entry_t        r_mem [QUEUE_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state, w_state_next;
  logic          r_req, r_we, r_cur_wb, r_wb_en, r_illegal, r_overflow;
  logic [15:0]   r_addr, r_wdata, r_wb_data;
  logic [4:0]    r_cur_wa, r_wb_addr;

  logic          w_ls_a, w_ls_b, w_ok_a, w_ok_b, w_acc_a, w_acc_b, w_pop, w_done;
  logic [CW-1:0] w_space;
  entry_t        w_ent_a, w_ent_b, w_head;

  assign w_ls_a  = lsOpCodeA_i == LOAD_OPCODE || lsOpCodeA_i == STORE_OPCODE;
  assign w_ls_b  = lsOpCodeB_i == LOAD_OPCODE || lsOpCodeB_i == STORE_OPCODE;
  assign w_ok_a  = lsEnableA_i && w_ls_a;
  assign w_ok_b  = lsEnableB_i && w_ls_b;
  assign w_ent_a = '{lsOpCodeA_i == STORE_OPCODE, isWbLSA_i, lsWbAddressA_i, lsPoperandA_i, lsSoperandA_i};
  assign w_ent_b = '{lsOpCodeB_i == STORE_OPCODE, isWbLSB_i, lsWbAddressB_i, lsPoperandB_i, lsSoperandB_i};
  assign w_head  = r_mem[r_rd_ptr];

  // A slot freed by this cycle's pop is reusable in the same cycle; A wins the last slot.
  assign w_space = DEPTH - r_count + CW'(w_pop);
  assign w_acc_a = w_ok_a && w_space != '0;
  assign w_acc_b = w_ok_b && w_space > CW'(w_acc_a);

  assign stall_o = (DEPTH - r_count) < CW'(2);

  // Pops only look at entries present before this edge, so a new entry is never bypassed.
  always_comb begin
    w_done       = r_state == BUSY && memAck_i;
    w_pop        = (r_state == IDLE || w_done) && r_count != '0;
    w_state_next = w_pop ? BUSY : (w_done ? IDLE : r_state);
  end

  always_ff @(posedge clock_i) begin
    if (w_acc_a) r_mem[r_wr_ptr] <= w_ent_a;
    if (w_acc_b) r_mem[r_wr_ptr + PW'(w_acc_a)] <= w_ent_b;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cur_wb   <= 1'b0;
      r_cur_wa   <= '0;
      r_wb_en    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_ptr   <= r_wr_ptr + PW'(w_acc_a) + PW'(w_acc_b);
      r_rd_ptr   <= r_rd_ptr + PW'(w_pop);
      r_count    <= r_count + CW'(w_acc_a) + CW'(w_acc_b) - CW'(w_pop);
      r_illegal  <= (lsEnableA_i && !w_ls_a) || (lsEnableB_i && !w_ls_b);
      r_overflow <= r_overflow || (w_ok_a && !w_acc_a) || (w_ok_b && !w_acc_b);
      r_wb_en    <= w_done && !r_we && r_cur_wb;
      if (w_done && !r_we) begin
        r_wb_addr <= r_cur_wa;
        r_wb_data <= memRdata_i;
      end
      if (w_pop) begin
        r_req    <= 1'b1;
        r_we     <= w_head.st;
        r_addr   <= w_head.addr;
        r_wdata  <= w_head.wd;
        r_cur_wb <= w_head.wb;
        r_cur_wa <= w_head.wa;
      end else if (w_done) begin
        r_req <= 1'b0;
      end
    end
  end

  assign memReq_o    = r_req;
  assign memWe_o     = r_we;
  assign memAddr_o   = r_addr;
  assign memWdata_o  = r_wdata;
  assign wbEnable_o  = r_wb_en;
  assign wbAddress_o = r_wb_addr;
  assign wbData_o    = r_wb_data;
  assign illegal_o   = r_illegal;
  assign overflow_o  = r_overflow;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios plus a randomized run scored against a transaction-level queue model
module tb_load_store_unit;
  localparam int D = 4;
  localparam logic [6:0] LD = 7'h20;
  localparam logic [6:0] ST = 7'h21;

  typedef struct packed {
    logic        st;
    logic        wb;
    logic [4:0]  wa;
    logic [15:0] addr;
    logic [15:0] wd;
  } op_t;

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  logic lsEnableA_i, lsEnableB_i, isWbLSA_i, isWbLSB_i;
  logic [4:0] lsWbAddressA_i, lsWbAddressB_i;
  logic [6:0] lsOpCodeA_i, lsOpCodeB_i;
  logic [15:0] lsPoperandA_i, lsPoperandB_i, lsSoperandA_i, lsSoperandB_i;
  logic stall_o, memReq_o, memWe_o, memAck_i, wbEnable_o, illegal_o, overflow_o;
  logic [15:0] memAddr_o, memWdata_o, memRdata_i, wbData_o;
  logic [4:0] wbAddress_o;

  int n_checks = 0;
  int n_fail = 0;

  load_store_unit #(.QUEUE_DEPTH(D)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .lsEnableA_i(lsEnableA_i), .lsEnableB_i(lsEnableB_i),
    .isWbLSA_i(isWbLSA_i), .isWbLSB_i(isWbLSB_i),
    .lsWbAddressA_i(lsWbAddressA_i), .lsWbAddressB_i(lsWbAddressB_i),
    .lsOpCodeA_i(lsOpCodeA_i), .lsOpCodeB_i(lsOpCodeB_i),
    .lsPoperandA_i(lsPoperandA_i), .lsPoperandB_i(lsPoperandB_i),
    .lsSoperandA_i(lsSoperandA_i), .lsSoperandB_i(lsSoperandB_i),
    .stall_o(stall_o), .memReq_o(memReq_o), .memWe_o(memWe_o),
    .memAddr_o(memAddr_o), .memWdata_o(memWdata_o),
    .memAck_i(memAck_i), .memRdata_i(memRdata_i),
    .wbEnable_o(wbEnable_o), .wbAddress_o(wbAddress_o), .wbData_o(wbData_o),
    .illegal_o(illegal_o), .overflow_o(overflow_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic set_lane(input int l, input logic en, input logic [6:0] op, input logic wb,
                          input logic [4:0] wa, input logic [15:0] addr, input logic [15:0] wd);
    if (l == 0) begin
      lsEnableA_i = en; lsOpCodeA_i = op; isWbLSA_i = wb;
      lsWbAddressA_i = wa; lsPoperandA_i = addr; lsSoperandA_i = wd;
    end else begin
      lsEnableB_i = en; lsOpCodeB_i = op; isWbLSB_i = wb;
      lsWbAddressB_i = wa; lsPoperandB_i = addr; lsSoperandB_i = wd;
    end
  endtask

  // Disabled lanes still carry a valid opcode so enable gating is exercised everywhere.
  task automatic clear_lanes();
    set_lane(0, 1'b0, LD, 1'b1, 5'd31, 16'hDEAD, 16'hDEAD);
    set_lane(1, 1'b0, ST, 1'b1, 5'd30, 16'hBEAD, 16'hBEAD);
  endtask

  task automatic test_reset();
    clear_lanes();
    memAck_i = 1'b0;
    memRdata_i = 16'h0;
    reset_i = 1'b0;
    set_lane(0, 1'b1, LD, 1'b1, 5'd1, 16'h1, 16'h0);
    repeat (2) @(negedge clock_i);
    n_checks++;
    if ({memReq_o, memWe_o, wbEnable_o, illegal_o, overflow_o, stall_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {memReq_o, memWe_o, wbEnable_o, illegal_o, overflow_o, stall_o});
    end
    n_checks++;
    if ({memAddr_o, memWdata_o, wbAddress_o, wbData_o} !== 53'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {memAddr_o, memWdata_o, wbAddress_o, wbData_o});
    end
    clear_lanes();
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    n_checks++;
    if (memReq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_enqueue: memReq_o got %b expected 0", memReq_o);
    end
  endtask

  task automatic test_single_load();
    set_lane(0, 1'b1, LD, 1'b1, 5'd5, 16'h0040, 16'h0);
    @(negedge clock_i);
    clear_lanes();
    n_checks++;
    if (memReq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_bypass: memReq_o got %b expected 0", memReq_o);
    end
    @(negedge clock_i);
    n_checks++;
    if ({memReq_o, memWe_o, memAddr_o} !== {1'b1, 1'b0, 16'h0040}) begin
      n_fail++;
      $display("FAIL single_req1: req/we/addr got %b/%b/%h expected 1/0/0040", memReq_o, memWe_o, memAddr_o);
    end
    @(negedge clock_i);
    n_checks++;
    if ({memReq_o, memWe_o, memAddr_o} !== {1'b1, 1'b0, 16'h0040}) begin
      n_fail++;
      $display("FAIL single_req2: req/we/addr got %b/%b/%h expected 1/0/0040", memReq_o, memWe_o, memAddr_o);
    end
    memAck_i = 1'b1;
    memRdata_i = 16'hBEEF;
    @(negedge clock_i);
    memAck_i = 1'b0;
    memRdata_i = 16'h0;
    n_checks++;
    if ({wbEnable_o, wbAddress_o, wbData_o, memReq_o} !== {1'b1, 5'd5, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL single_wb: en/addr/data/req got %b/%0d/%h/%b expected 1/5/beef/0",
               wbEnable_o, wbAddress_o, wbData_o, memReq_o);
    end
    @(negedge clock_i);
    n_checks++;
    if ({wbEnable_o, wbData_o} !== {1'b0, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL single_wb_pulse: en/data got %b/%h expected 0/beef", wbEnable_o, wbData_o);
    end
  endtask

  task automatic test_dual_issue();
    logic [32:0] reqs [4];
    int nreq = 0, nwb = 0;
    logic [20:0] wb_seen = '0;
    set_lane(0, 1'b1, ST, 1'b1, 5'd9, 16'h0010, 16'h1234);
    set_lane(1, 1'b1, LD, 1'b1, 5'd3, 16'h0010, 16'h0);
    memAck_i = 1'b1;
    memRdata_i = 16'h5A5A;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock_i);
      clear_lanes();
      if (memReq_o && nreq < 4) begin reqs[nreq] = {memWe_o, memAddr_o, memWdata_o}; nreq++; end
      if (wbEnable_o) begin nwb++; wb_seen = {wbAddress_o, wbData_o}; end
    end
    memAck_i = 1'b0;
    n_checks++;
    if (nreq !== 2) begin
      n_fail++;
      $display("FAIL dual_req_count: got %0d expected 2", nreq);
    end else begin
      n_checks++;
      if (reqs[0] !== {1'b1, 16'h0010, 16'h1234}) begin
        n_fail++;
        $display("FAIL dual_store_first: got %h expected %h", reqs[0], {1'b1, 16'h0010, 16'h1234});
      end
      n_checks++;
      if (reqs[1][32:16] !== {1'b0, 16'h0010}) begin
        n_fail++;
        $display("FAIL dual_load_second: we/addr got %h expected 00010", reqs[1][32:16]);
      end
    end
    n_checks++;
    if (nwb !== 1 || wb_seen !== {5'd3, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL dual_wb: count %0d reg/data %h expected 1 and %h", nwb, wb_seen, {5'd3, 16'h5A5A});
    end
  endtask

  task automatic test_illegal();
    set_lane(1, 1'b1, 7'h05, 1'b1, 5'd1, 16'h0, 16'h0);
    @(negedge clock_i);
    clear_lanes();
    n_checks++;
    if ({illegal_o, memReq_o, stall_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL illegal_pulse: ill/req/stall got %b expected 100", {illegal_o, memReq_o, stall_o});
    end
    @(negedge clock_i);
    n_checks++;
    if ({illegal_o, memReq_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_clear: ill/req got %b expected 00", {illegal_o, memReq_o});
    end
    set_lane(0, 1'b1, 7'h7F, 1'b1, 5'd1, 16'h0, 16'h0);
    set_lane(1, 1'b1, 7'h00, 1'b1, 5'd2, 16'h0, 16'h0);
    @(negedge clock_i);
    clear_lanes();
    n_checks++;
    if (illegal_o !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_both: got %b expected 1", illegal_o);
    end
    @(negedge clock_i);
    n_checks++;
    if ({illegal_o, memReq_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_both_clear: ill/req got %b expected 00", {illegal_o, memReq_o});
    end
  endtask

  task automatic test_wrap();
    int issued = 0, nreq = 0, nwb = 0;
    for (int c = 0; c < 60; c++) begin
      if (issued < 10 && !stall_o) begin
        set_lane(0, 1'b1, LD, 1'b1, 5'(issued + 1), 16'(issued), 16'h0);
        issued++;
      end else clear_lanes();
      memAck_i = 1'b1;
      memRdata_i = memAddr_o ^ 16'hA5A5;
      @(negedge clock_i);
      if (memReq_o) begin
        n_checks++;
        if (memAddr_o !== 16'(nreq)) begin
          n_fail++;
          $display("FAIL wrap_req_order: addr got %h expected %h", memAddr_o, 16'(nreq));
        end
        nreq++;
      end
      if (wbEnable_o) begin
        n_checks++;
        if ({wbAddress_o, wbData_o} !== {5'(nwb + 1), 16'(nwb) ^ 16'hA5A5}) begin
          n_fail++;
          $display("FAIL wrap_wb: reg/data got %0d/%h expected %0d/%h",
                   wbAddress_o, wbData_o, nwb + 1, 16'(nwb) ^ 16'hA5A5);
        end
        nwb++;
      end
    end
    clear_lanes();
    memAck_i = 1'b0;
    n_checks++;
    if (nreq !== 10 || nwb !== 10) begin
      n_fail++;
      $display("FAIL wrap_counts: requests %0d writebacks %0d expected 10 and 10", nreq, nwb);
    end
  endtask

  task automatic test_fill_stall();
    logic [15:0] got [8];
    int nreq = 0;
    memAck_i = 1'b0;
    set_lane(0, 1'b1, LD, 1'b0, 5'd0, 16'h0100, 16'h0);
    set_lane(1, 1'b1, LD, 1'b0, 5'd0, 16'h0101, 16'h0);
    @(negedge clock_i);
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_two_free: stall got %b expected 0", stall_o);
    end
    set_lane(0, 1'b1, LD, 1'b0, 5'd0, 16'h0102, 16'h0);
    set_lane(1, 1'b1, LD, 1'b0, 5'd0, 16'h0103, 16'h0);
    @(negedge clock_i);
    n_checks++;
    if ({stall_o, overflow_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL fill_stall: stall/ovf got %b expected 10", {stall_o, overflow_o});
    end
    set_lane(0, 1'b1, LD, 1'b0, 5'd0, 16'h0104, 16'h0);
    set_lane(1, 1'b1, LD, 1'b0, 5'd0, 16'h0105, 16'h0);
    @(negedge clock_i);
    clear_lanes();
    n_checks++;
    if ({stall_o, overflow_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL fill_overflow: stall/ovf got %b expected 11", {stall_o, overflow_o});
    end
    @(negedge clock_i);
    for (int c = 0; c < 20; c++) begin
      if (memReq_o && nreq < 8) begin got[nreq] = memAddr_o; nreq++; end
      memAck_i = 1'b1;
      @(negedge clock_i);
    end
    memAck_i = 1'b0;
    n_checks++;
    if (nreq !== 5) begin
      n_fail++;
      $display("FAIL fill_drain_count: got %0d expected 5", nreq);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got[i] !== 16'h0100 + 16'(i)) begin
          n_fail++;
          $display("FAIL fill_drain_order[%0d]: got %h expected %h", i, got[i], 16'h0100 + 16'(i));
        end
      end
    end
    n_checks++;
    if (overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_sticky: ovf got %b expected 1", overflow_o);
    end
  endtask

  task automatic test_async_reset();
    memAck_i = 1'b0;
    set_lane(0, 1'b1, LD, 1'b1, 5'd1, 16'h0200, 16'h0);
    set_lane(1, 1'b1, LD, 1'b1, 5'd2, 16'h0201, 16'h0);
    @(negedge clock_i);
    set_lane(0, 1'b1, LD, 1'b1, 5'd3, 16'h0202, 16'h0);
    set_lane(1, 1'b1, LD, 1'b1, 5'd4, 16'h0203, 16'h0);
    @(negedge clock_i);
    clear_lanes();
    n_checks++;
    if ({memReq_o, stall_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL areset_setup: req/stall got %b expected 11", {memReq_o, stall_o});
    end
    #2 reset_i = 1'b0;
    #1;
    n_checks++;
    if ({memReq_o, stall_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL areset_immediate: req/stall got %b expected 00", {memReq_o, stall_o});
    end
    @(negedge clock_i);
    reset_i = 1'b1;
    memAck_i = 1'b1;
    memRdata_i = 16'h1111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock_i);
      n_checks++;
      if ({wbEnable_o, memReq_o, overflow_o, stall_o} !== 4'b0) begin
        n_fail++;
        $display("FAIL areset_after[%0d]: wb/req/ovf/stall got %b expected 0000", c,
                 {wbEnable_o, memReq_o, overflow_o, stall_o});
      end
    end
    memAck_i = 1'b0;
  endtask

  // Model: the unit is an in-order queue that keeps a request outstanding whenever it holds
  // work; each ack retires the current op and loads with a writeback flag return the ack data.
  task automatic test_random();
    op_t q[$];
    op_t cur = '0;
    logic prev_req, prev_ack = 1'b0, exp_ill = 1'b0, exp_wb, exp_req, exp_stall;
    logic [15:0] prev_rd = '0;
    int prev_size = 0;
    prev_req = memReq_o;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock_i);
      exp_wb = prev_req && prev_ack && !cur.st && cur.wb;
      n_checks++;
      if (wbEnable_o !== exp_wb) begin
        n_fail++;
        $display("FAIL rnd_wb_en @%0d: got %b expected %b", c, wbEnable_o, exp_wb);
      end
      if (exp_wb) begin
        n_checks++;
        if ({wbAddress_o, wbData_o} !== {cur.wa, prev_rd}) begin
          n_fail++;
          $display("FAIL rnd_wb_data @%0d: got %0d/%h expected %0d/%h", c, wbAddress_o, wbData_o, cur.wa, prev_rd);
        end
      end
      exp_req = (prev_req && !prev_ack) || prev_size > 0;
      n_checks++;
      if (memReq_o !== exp_req) begin
        n_fail++;
        $display("FAIL rnd_req @%0d: got %b expected %b", c, memReq_o, exp_req);
      end
      if (memReq_o && (!prev_req || prev_ack)) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious_req @%0d: request with model queue size 0 expected >0", c);
        end else cur = q.pop_front();
      end
      if (memReq_o) begin
        n_checks++;
        if (memWe_o !== cur.st || memAddr_o !== cur.addr || (cur.st && memWdata_o !== cur.wd)) begin
          n_fail++;
          $display("FAIL rnd_req_fields @%0d: we/addr/wdata got %b/%h/%h expected %b/%h/%h",
                   c, memWe_o, memAddr_o, memWdata_o, cur.st, cur.addr, cur.wd);
        end
      end
      exp_stall = (D - q.size()) < 2;
      n_checks++;
      if (stall_o !== exp_stall) begin
        n_fail++;
        $display("FAIL rnd_stall @%0d: got %b expected %b", c, stall_o, exp_stall);
      end
      n_checks++;
      if ({illegal_o, overflow_o} !== {exp_ill, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd_ill_ovf @%0d: got %b expected %b", c, {illegal_o, overflow_o}, {exp_ill, 1'b0});
      end
      prev_req = memReq_o;
      prev_size = q.size();
      exp_ill = 1'b0;
      clear_lanes();
      if (c < 1450 && !stall_o) begin
        for (int l = 0; l < 2; l++) begin
          logic en;
          int kind;
          op_t e;
          logic [6:0] op;
          en = 1'($urandom_range(0, 1));
          kind = $urandom_range(0, 7);
          e.st = kind >= 1 && kind < 4;
          e.wb = 1'($urandom_range(0, 1));
          e.wa = 5'($urandom);
          e.addr = 16'($urandom);
          e.wd = 16'($urandom);
          op = kind == 0 ? 7'($urandom_range(0, 31)) : (e.st ? ST : LD);
          set_lane(l, en, op, e.wb, e.wa, e.addr, e.wd);
          if (en && kind == 0) exp_ill = 1'b1;
          else if (en) q.push_back(e);
        end
      end
      memAck_i = $urandom_range(0, 2) != 0;
      memRdata_i = 16'($urandom);
      prev_ack = memAck_i;
      prev_rd = memRdata_i;
    end
    clear_lanes();
    memAck_i = 1'b0;
    n_checks++;
    if (q.size() != 0 || memReq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_drain: model queue %0d req %b expected 0 and 0", q.size(), memReq_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_dual_issue();
    test_illegal();
    test_wrap();
    test_fill_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
